// File: rtl/div_reconstruct_mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_recon_pkg                                                  |
// | Desc     : Shared types and sizing for the dividend reconstruction MAC.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package div_recon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);

endpackage
`default_nettype wire

// File: rtl/div_reconstruct_mac_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_reconstruct_mac_if                                         |
// | Desc     : Start/busy/done operand and result bundle for the MAC.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface div_reconstruct_mac_if
    import div_recon_pkg::*;
#(
    parameter int N = N_DEF
);
    logic             start;
    logic [N-1:0]     quotient;
    logic [N-1:0]     divisor;
    logic [N-1:0]     remainder;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   result;

`ifdef DIV_RECON_CHECK_EN
    logic             err;

    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, result, err
    );
    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, result, err
    );
`else
    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, result
    );
    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, result
    );
`endif

endinterface
`default_nettype wire

// File: rtl/div_reconstruct_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_reconstruct_mac                                            |
// | Desc     : Sequential shift-add rebuild of quotient*divisor + remainder.  |
// |            Optional err output enabled by `DIV_RECON_CHECK_EN.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module div_reconstruct_mac
    import div_recon_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    div_reconstruct_mac_if.slave bus
);

    localparam int OW = 2 * N;
    localparam int CW = (N == N_DEF) ? CNT_W : cnt_width(N);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_d;
    logic [OW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [OW-1:0]   r_result;
    logic            r_done;
    logic [OW-1:0]   w_addend;

    assign w_addend = {{N{1'b0}}, r_d} << r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == c_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_d      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q   <= bus.quotient;
                        r_d   <= bus.divisor;
                        r_acc <= {{N{1'b0}}, bus.remainder};
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    if (r_q[r_cnt]) r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;

`ifdef DIV_RECON_CHECK_EN
    logic [N-1:0] r_r;
    logic         r_err;

    // Sanity flag on the captured operands: a valid division leaves r < d.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r   <= '0;
            r_err <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_r <= bus.remainder;
        end else if (r_state == DONE) begin
            r_err <= (r_r >= r_d) || (r_d == '0);
        end
    end

    assign bus.err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_reconstruct_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_div_reconstruct_mac                                         |
// | Desc     : Vector table, corner sequences and random ops vs q*d+r model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_div_reconstruct_mac;
    import div_recon_pkg::*;

    localparam int N  = 4;
    localparam int OW = 2 * N;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    div_reconstruct_mac_if #(.N(N)) bus ();

    div_reconstruct_mac #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0]  q;
        logic [N-1:0]  d;
        logic [N-1:0]  r;
        logic [OW-1:0] exp;
        logic          exp_err;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [OW-1:0] model_result(input int q, input int d, input int r);
        return OW'(q * d + r);
    endfunction

    function automatic logic model_err(input int d, input int r);
        return (r >= d) || (d == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete operation; operands are scrambled during RUN to prove capture.
    task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                          output logic [OW-1:0] res, output logic e);
        int lat;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        lat = 0;
        do begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.quotient  = N'($urandom);
            bus.divisor   = N'($urandom);
            bus.remainder = N'($urandom);
            lat++;
            if (lat <= 6) chk("busy_during_op", 32'(bus.busy), 32'(lat <= 5));
        end while (!bus.done && lat < 20);
        chk("latency", 32'(lat), 32'd6);
        res = bus.result;
`ifdef DIV_RECON_CHECK_EN
        e = bus.err;
`else
        e = 1'b0;
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("result_hold", 32'(bus.result), 32'(res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] res;
        logic          e;
        logic [N-1:0]  q, d, r;
        int            dones;

        tbl[0] = '{q: 4'd2,  d: 4'd5,  r: 4'd3,  exp: 8'h0D, exp_err: 1'b0};
        tbl[1] = '{q: 4'd13, d: 4'd6,  r: 4'd4,  exp: 8'h52, exp_err: 1'b0};
        tbl[2] = '{q: 4'd15, d: 4'd7,  r: 4'd5,  exp: 8'h6E, exp_err: 1'b0};
        tbl[3] = '{q: 4'd15, d: 4'd15, r: 4'd15, exp: 8'hF0, exp_err: 1'b1};
        tbl[4] = '{q: 4'd9,  d: 4'd0,  r: 4'd4,  exp: 8'h04, exp_err: 1'b1};
        tbl[5] = '{q: 4'd0,  d: 4'd9,  r: 4'd4,  exp: 8'h04, exp_err: 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.quotient = '0;
        bus.divisor = '0;
        bus.remainder = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
`ifdef DIV_RECON_CHECK_EN
        chk("reset_err", 32'(bus.err), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].q, tbl[i].d, tbl[i].r, res, e);
            chk("table_result", 32'(res), 32'(tbl[i].exp));
`ifdef DIV_RECON_CHECK_EN
            chk("table_err", 32'(e), 32'(tbl[i].exp_err));
`endif
        end

        // Second start while busy is ignored; result not cleared by a new start.
        @(negedge clk);
        bus.start = 1'b1; bus.quotient = 4'd3; bus.divisor = 4'd7; bus.remainder = 4'd3;
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start = (k == 2);
            if (k == 2) begin
                bus.quotient = 4'd1; bus.divisor = 4'd1; bus.remainder = 4'd0;
            end
            if (k == 1) chk("result_kept_on_start", 32'(bus.result), 32'h04);
            if (k <= 5) chk("busy_through_restart", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                dones++;
                chk("restart_ignored_result", 32'(bus.result), 32'h18);
                chk("restart_done_time", 32'(k), 32'd6);
            end
        end
        bus.start = 1'b0;
        chk("restart_single_done", 32'(dones), 32'd1);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.quotient = 4'd12; bus.divisor = 4'd7; bus.remainder = 4'd2;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
        chk("midrun_rst_result", 32'(bus.result), 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        chk("midrun_rst_no_done", 32'(dones), 32'd0);
        run_op(4'd12, 4'd7, 4'd2, res, e);
        chk("after_rst_result", 32'(res), 32'h56);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_beats_start_busy", 32'(bus.busy), 32'd0);
        chk("rst_beats_start_result", 32'(bus.result), 32'd0);

        for (int i = 0; i < 40; i++) begin
            q = N'($urandom_range(0, 15));
            d = N'($urandom_range(0, 15));
            r = N'($urandom_range(0, 15));
            run_op(q, d, r, res, e);
            chk("random_result", 32'(res), 32'(model_result(int'(q), int'(d), int'(r))));
`ifdef DIV_RECON_CHECK_EN
            chk("random_err", 32'(e), 32'(model_err(int'(d), int'(r))));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
